// File: rtl/cpu_ctrl_pkg.sv
// Shared phase encoding, opcode constants and opcode classification for the CPU control sequencer.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        EXEC1   = 3'd1,
        EXEC2   = 3'd2,
        MULWAIT = 3'd3,
        EXEC3   = 3'd4,
        HALT    = 3'd5
    } phase_t;

    localparam logic [3:0] OP_STA = 4'b0000;
    localparam logic [3:0] OP_JMP = 4'b0001;
    localparam logic [3:0] OP_STP = 4'b0010;
    localparam logic [3:0] OP_LDA = 4'b0011;
    localparam logic [3:0] OP_JMS = 4'b0100;
    localparam logic [3:0] OP_BBL = 4'b0101;
    localparam logic [3:0] OP_JEQ = 4'b0110;
    localparam logic [3:0] OP_MUL = 4'b1101;
    localparam logic [3:0] OP_LDR = 4'b1110;

    // Extended instructions need a second execute phase.
    function automatic logic is_ext(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_LDR) || (op == OP_MUL);
    endfunction

    function automatic logic is_known(input logic [3:0] op);
        case (op)
            OP_STA, OP_JMP, OP_STP, OP_LDA, OP_JMS,
            OP_BBL, OP_JEQ, OP_MUL, OP_LDR: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_call_depth.sv
// Saturating call-stack occupancy counter; full/empty feed the overflow/underflow checks.
module cpu_call_depth #(
    parameter int STACK_DEPTH = 4,
    parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
);

    logic [DEPTH_W-1:0] depth_q;

    assign full  = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign empty = (depth_q == '0);
    assign depth = depth_q;

    always_ff @(posedge clk) begin
        if (reset)
            depth_q <= '0;
        else if (push && !full)
            depth_q <= depth_q + 1'b1;
        else if (pop && !empty)
            depth_q <= depth_q - 1'b1;
    end

endmodule

// File: rtl/cpu_control_seq.sv
// Harvard CPU decoder + phase sequencer. Optional macro ILLEGAL_TRAP_EN: undefined opcodes fault and halt
// instead of executing as a NOP.
module cpu_control_seq
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 4,
    parameter int MUL_CYCLES  = 2,
    parameter int STACK_DEPTH = 4,
    parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] inst,
    input  logic                eq,
    input  logic                mem_ready,
    output logic [2:0]          phase,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                acc_load,
    output logic                WrEn,
    output logic                push,
    output logic                pop,
    output logic                stack_mux,
    output logic                data_mux,
    output logic                e,
    output logic                m,
    output logic                halted,
    output logic                fault,
    output logic [DEPTH_W-1:0]  depth
);

    localparam int CNT_W = $clog2(MUL_CYCLES + 1);

    phase_t              state_q, state_d;
    logic [OPCODE_W-1:0] ir_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                fault_q;
    logic [3:0]          op;
    logic                upper_zero, known, ext, in_exec;
    logic                full, empty;
    logic                ld_cnt, set_fault;
    logic                inc_r, load_r, acc_r, wr_r, push_r, pop_r;

    assign op = ir_q[3:0];

    generate
        if (OPCODE_W > 4) begin : g_upper
            assign upper_zero = ~|ir_q[OPCODE_W-1:4];
        end else begin : g_no_upper
            assign upper_zero = 1'b1;
        end
    endgenerate

    assign known   = upper_zero && is_known(op);
    assign ext     = upper_zero && is_ext(op);
    assign in_exec = (state_q != FETCH) && (state_q != HALT);

    always_comb begin
        state_d   = state_q;
        inc_r     = 1'b0;
        load_r    = 1'b0;
        acc_r     = 1'b0;
        wr_r      = 1'b0;
        push_r    = 1'b0;
        pop_r     = 1'b0;
        ld_cnt    = 1'b0;
        set_fault = 1'b0;
        case (state_q)
            FETCH: if (mem_ready) begin
                inc_r   = 1'b1;
                state_d = EXEC1;
            end
            EXEC1: if (mem_ready) begin
                if (!known) begin
`ifdef ILLEGAL_TRAP_EN
                    set_fault = 1'b1;
                    state_d   = HALT;
`else
                    inc_r   = 1'b1;
                    state_d = FETCH;
`endif
                end else begin
                    state_d = FETCH;
                    case (op)
                        OP_STP: state_d = HALT;
                        // Stack faults halt with every strobe withheld, like stp.
                        OP_JMS: if (full) begin
                            set_fault = 1'b1;
                            state_d   = HALT;
                        end else begin
                            inc_r  = 1'b1;
                            load_r = 1'b1;
                            push_r = 1'b1;
                        end
                        OP_BBL: if (empty) begin
                            set_fault = 1'b1;
                            state_d   = HALT;
                        end else begin
                            inc_r  = 1'b1;
                            load_r = 1'b1;
                            pop_r  = 1'b1;
                        end
                        OP_STA: begin
                            inc_r = 1'b1;
                            wr_r  = 1'b1;
                        end
                        OP_JMP: begin
                            inc_r  = 1'b1;
                            load_r = 1'b1;
                        end
                        OP_JEQ: begin
                            inc_r  = 1'b1;
                            load_r = !eq;
                        end
                        default: state_d = EXEC2;
                    endcase
                end
            end
            EXEC2: if (mem_ready) begin
                if (op == OP_MUL) begin
                    ld_cnt  = 1'b1;
                    state_d = MULWAIT;
                end else begin
                    acc_r   = 1'b1;
                    inc_r   = 1'b1;
                    state_d = FETCH;
                end
            end
            MULWAIT: if (mem_ready && cnt_q == '0) state_d = EXEC3;
            EXEC3: if (mem_ready) begin
                inc_r   = 1'b1;
                state_d = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            ir_q    <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH && mem_ready)
                ir_q <= inst;
            // The wait counter runs freely; only leaving MULWAIT waits on mem_ready.
            if (ld_cnt)
                cnt_q <= CNT_W'(MUL_CYCLES - 1);
            else if (state_q == MULWAIT && cnt_q != '0)
                cnt_q <= cnt_q - 1'b1;
            if (set_fault)
                fault_q <= 1'b1;
        end
    end

    // A cycle with reset high aborts the instruction, so no strobe leaves the block.
    assign pc_inc   = inc_r  & ~reset;
    assign pc_load  = load_r & ~reset;
    assign acc_load = acc_r  & ~reset;
    assign WrEn     = wr_r   & ~reset;
    assign push     = push_r & ~reset;
    assign pop      = pop_r  & ~reset;

    assign phase     = state_q;
    assign e         = in_exec && ext;
    assign m         = in_exec && upper_zero && (op == OP_MUL);
    assign stack_mux = in_exec && upper_zero && (op == OP_BBL);
    assign data_mux  = in_exec && upper_zero && (op == OP_LDR);
    assign halted    = (state_q == HALT);
    assign fault     = fault_q;

    cpu_call_depth #(
        .STACK_DEPTH (STACK_DEPTH),
        .DEPTH_W     (DEPTH_W)
    ) u_call_depth (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .depth (depth),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: doc/cpu_control_seq.md
Name: cpu_control_seq

Overview:
- Parametrised control unit for the Harvard CPU: the instruction decoder and its phase sequencer merged into one block.
- Owns the fetch/exec state machine, the opcode register, the multiply wait counter, the call-stack depth counter and halt/fault status.
- Drives the PC, accumulator, data memory, stack and datapath muxes.
- Sits between the instruction memory output and the datapath.

Parameters:
- OPCODE_W, 4, opcode width (>=4); bits above [3:0] must be zero for a legal opcode.
- MUL_CYCLES, 2, number of MULWAIT cycles inserted for mul (>=1).
- STACK_DEPTH, 4, call-stack entries (>=1).
- DEPTH_W, $clog2(STACK_DEPTH+1), width of the depth output.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- inst  in  OPCODE_W  opcode from instruction memory; sampled in FETCH.
- eq  in  1  comparator result from datapath.
- mem_ready  in  1  memory handshake; the current phase completes only when high.
- phase  out  3  current state encoding (see package).
- pc_inc  out  1  PC increment strobe.
- pc_load  out  1  PC load strobe.
- acc_load  out  1  accumulator load strobe.
- WrEn  out  1  data memory write strobe.
- push  out  1  stack push strobe.
- pop  out  1  stack pop strobe.
- stack_mux  out  1  PC source = stack top.
- data_mux  out  1  accumulator source = register path.
- e  out  1  extended instruction (lda/ldr/mul), level.
- m  out  1  multiply in progress, level.
- halted  out  1  block is in HALT.
- fault  out  1  sticky error flag.
- depth  out  DEPTH_W  current call-stack occupancy.

Behaviour:
- Opcodes (low 4 bits, upper bits zero):
  - sta=0000, jmp=0001, stp=0010, lda=0011, jms=0100, bbl=0101, jeq=0110, mul=1101, ldr=1110.
  - All other values are undefined.
- States: FETCH, EXEC1, EXEC2, MULWAIT, EXEC3, HALT.
- A state advances only in a cycle where mem_ready=1; otherwise it holds.
- All strobes (pc_inc, pc_load, acc_load, WrEn, push, pop) assert only in the advancing cycle. They are zero while stalled.
- FETCH: ir<=inst; pc_inc=1; next state EXEC1.
- EXEC1:
  - pc_inc=1 if not e.
  - sta: WrEn=1.
  - jmp/bbl/jms: pc_load=1.
  - jeq: pc_load=1 when eq=0.
  - jms: push=1. bbl: pop=1.
  - stp: next HALT, no strobes.
  - e instructions: next EXEC2. All others: next FETCH.
- EXEC2:
  - lda/ldr: acc_load=1, pc_inc=1, next FETCH.
  - mul: no pc_inc; load counter with MUL_CYCLES-1; next MULWAIT.
- MULWAIT:
  - Counter decrements each cycle regardless of mem_ready.
  - At 0, go to EXEC3.
- EXEC3 (mul only): pc_inc=1, next FETCH.
- Level outputs, valid in every state except FETCH and HALT (0 in those two):
  - e = ir is lda/ldr/mul.
  - m = ir is mul.
  - stack_mux = ir is bbl.
  - data_mux = ir is ldr.
- Stack depth:
  - Increments on push, decrements on pop.
  - jms at depth==STACK_DEPTH: overflow. Suppress push and pc_load, set fault, go HALT.
  - bbl at depth==0: underflow. Suppress pop and pc_load, set fault, go HALT.
- HALT: absorbing. All strobes 0, halted=1, depth and fault hold. Exit only via reset.
- Reset:
  - phase=FETCH, ir=0, counter=0, depth=0, fault=0, halted=0, all strobes 0.
  - Reset asserted mid-instruction (any state, including MULWAIT) aborts it with no strobe in that cycle.
- jeq with eq changing during a stall: eq is sampled in the advancing cycle only.

Optional Feature:
- ILLEGAL_TRAP_EN
  - Defined: an undefined opcode in EXEC1 sets fault and goes HALT, no strobes.
  - Undefined: the undefined opcode executes as a NOP: pc_inc=1 in EXEC1, next FETCH, fault unaffected.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - phase enum: FETCH=0, EXEC1=1, EXEC2=2, MULWAIT=3, EXEC3=4, HALT=5.
  - 4-bit opcode constants OP_STA..OP_LDR.
  - A function is_ext(op).
- One natural sub-module: cpu_call_depth, the saturating depth counter with overflow/underflow detect, parametrised by STACK_DEPTH.

Test Plan:
- Reset, then lda (0011) with mem_ready=1: phases F,E1,E2,F; pc_inc in F, E2 only; acc_load=1 in E2; total 3 cycles.
- mul (1101), MUL_CYCLES=3: F,E1,E2,MW,MW,MW,E3,F; m=1 from E1 through E3; pc_inc in F and E3 only; 7 cycles total.
- jeq (0110) with eq=0 then eq=1: first gives pc_load=1 in E1, second gives pc_load=0 and pc_inc=1.
- STACK_DEPTH=2: three jms → depth 1, 2, then fault=1, halted=1, push=0, depth=2. Separately, bbl at depth 0 → fault=1.
- sta with mem_ready low 2 cycles in E1: WrEn=0 while stalled, WrEn=1 for exactly one cycle when mem_ready rises.
- Opcode 1000 under each macro setting:
  - ILLEGAL_TRAP_EN defined: fault=1, HALT.
  - Not defined: pc_inc in E1, returns to FETCH.
  - Also assert reset during MULWAIT → phase=FETCH, depth=0 next cycle.
